// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the alu_seq block
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd3;
    localparam logic [OP_W-1:0] OP_CAT  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd5;
    localparam logic [OP_W-1:0] OP_RAND = 4'd6;
    localparam logic [OP_W-1:0] OP_MAX  = 4'd7;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd8;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle datapath: bit-serial right shift and shift-add multiply
module alu_iter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         step_i,
    input  logic         mul_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] res_o
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] W_C = CW'(W);
    localparam logic [W-1:0]  W_V = W'(W);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mul_q, mul_d;
    logic [CW-1:0] shr_n;

    // Shift distances beyond W all produce zero, so clamp to W.
    assign shr_n = (b_i > W_V) ? W_C : b_i[CW-1:0];

    // res_o is the accumulator value this step produces; the top samples it on done_o.
    assign res_o  = mul_q ? (acc_q + (mplier_q[0] ? mcand_q : '0)) : (acc_q >> 1);
    assign done_o = step_i && (cnt_q == CW'(1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        mul_d    = mul_q;
        if (start_i) begin
            mul_d    = mul_i;
            cnt_d    = mul_i ? W_C : shr_n;
            acc_d    = mul_i ? '0 : a_i;
            mcand_d  = a_i;
            mplier_d = b_i;
        end else if (step_i) begin
            acc_d    = res_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            mul_q    <= mul_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked W-bit ALU with registered result and zero/carry/err flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    result,
    output logic            zero,
    output logic            carry,
    output logic            err
);

    state_t         state_q, state_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           carry_q, carry_d;
    logic           err_q, err_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           iterative;
    logic           iter_start, iter_step, iter_done;
    logic [W-1:0]   iter_res;
    logic [W-1:0]   s_res;
    logic           s_carry, s_err;
    logic [W:0]     sum;

    assign accept    = in_valid && in_ready;
    assign iterative = (op == OP_MUL) || ((op == OP_SHR) && (b != '0));

    always_comb begin
        s_res   = '0;
        s_carry = 1'b0;
        s_err   = 1'b0;
        sum     = {1'b0, a} + {1'b0, b};
        case (op)
            OP_AND:  s_res = a & b;
            OP_OR:   s_res = a | b;
            OP_XOR:  s_res = a ^ b;
            OP_NOT:  s_res = ~a;
            OP_CAT:  s_res = {a[W/2-1:0], b[W/2-1:0]};
            OP_SHR:  s_res = a;
            OP_RAND: s_res = {{(W-1){1'b0}}, &b};
            OP_MAX:  s_res = (a > b) ? a : b;
            OP_SUB: begin
                s_res   = a - b;
                s_carry = (a < b);
            end
            OP_ADD: begin
                s_res   = sum[W-1:0];
                s_carry = sum[W];
            end
            OP_MUL:  s_res = '0;
            default: s_err = 1'b1;
        endcase
    end

    alu_iter #(.W(W)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (iter_start),
        .step_i  (iter_step),
        .mul_i   (op == OP_MUL),
        .a_i     (a),
        .b_i     (b),
        .done_o  (iter_done),
        .res_o   (iter_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = iterative ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_d = ST_DONE;
            ST_DONE: if (out_valid_q && out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result and flags only move on the edge that enters DONE.
    always_comb begin
        in_ready    = (state_q == ST_IDLE) && !rst;
        iter_start  = accept && iterative;
        iter_step   = (state_q == ST_BUSY);
        out_valid_d = (state_d == ST_DONE);
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        err_d       = err_q;
        if (accept && !iterative) begin
            result_d = s_res;
            zero_d   = (s_res == '0);
            carry_d  = s_carry;
            err_d    = s_err;
        end else if (iter_done) begin
            result_d = iter_res;
            zero_d   = (iter_res == '0);
            carry_d  = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at W=8
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       err;

    int n_chk;
    int n_fail;
    int lat;

    alu_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    // Present one operation, let it be accepted, then wait (bounded) for out_valid.
    task automatic issue(input string tag, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        chk(tag, "in_ready_pre", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'd0;
        a = 8'hAA;
        b = 8'hAA;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk(tag, "in_ready_busy", in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic expect_res(input string tag, input logic [7:0] r, input logic z, input logic c,
                              input logic e, input int l);
        chk(tag, "out_valid", out_valid, 1);
        chk(tag, "latency", lat, l);
        chk(tag, "result", result, r);
        chk(tag, "zero", zero, z);
        chk(tag, "carry", carry, c);
        chk(tag, "err", err, e);
    endtask

    task automatic xfer(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk(tag, "out_valid_after", out_valid, 0);
        chk(tag, "in_ready_after", in_ready, 1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        op = 4'd0;
        a = 8'h00;
        b = 8'h00;
        out_ready = 1'b0;

        @(posedge clk);
        #1;
        chk("reset", "in_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset", "out_valid", out_valid, 0);
        chk("reset", "result", result, 0);
        chk("reset", "zero", zero, 0);
        chk("reset", "carry", carry, 0);
        chk("reset", "err", err, 0);
        chk("reset", "in_ready", in_ready, 1);

        issue("and", OP_AND, 8'h33, 8'hF0);   expect_res("and", 8'h30, 0, 0, 0, 1);   xfer("and");
        issue("or", OP_OR, 8'h33, 8'hF0);     expect_res("or", 8'hF3, 0, 0, 0, 1);    xfer("or");
        issue("xor", OP_XOR, 8'h33, 8'hF0);   expect_res("xor", 8'hC3, 0, 0, 0, 1);   xfer("xor");
        issue("not", OP_NOT, 8'h33, 8'hF0);   expect_res("not", 8'hCC, 0, 0, 0, 1);   xfer("not");
        issue("sub", OP_SUB, 8'h33, 8'hF0);   expect_res("sub", 8'h43, 0, 1, 0, 1);   xfer("sub");
        issue("cat", OP_CAT, 8'h33, 8'hF0);   expect_res("cat", 8'h30, 0, 0, 0, 1);   xfer("cat");
        issue("max", OP_MAX, 8'h33, 8'hF0);   expect_res("max", 8'hF0, 0, 0, 0, 1);   xfer("max");
        issue("rand", OP_RAND, 8'h33, 8'hF0); expect_res("rand", 8'h00, 1, 0, 0, 1);  xfer("rand");
        issue("rand1", OP_RAND, 8'h00, 8'hFF); expect_res("rand1", 8'h01, 0, 0, 0, 1); xfer("rand1");

        issue("shr3", OP_SHR, 8'h33, 8'd3);     expect_res("shr3", 8'h06, 0, 0, 0, 4);   xfer("shr3");
        issue("shr0", OP_SHR, 8'h33, 8'd0);     expect_res("shr0", 8'h33, 0, 0, 0, 1);   xfer("shr0");
        issue("shr200", OP_SHR, 8'h33, 8'd200); expect_res("shr200", 8'h00, 1, 0, 0, 9); xfer("shr200");
        issue("shr7", OP_SHR, 8'h80, 8'd7);     expect_res("shr7", 8'h01, 0, 0, 0, 8);   xfer("shr7");

        issue("mul", OP_MUL, 8'h0F, 8'h11);     expect_res("mul", 8'hFF, 0, 0, 0, 9);    xfer("mul");
        issue("mul0", OP_MUL, 8'h10, 8'h10);    expect_res("mul0", 8'h00, 1, 0, 0, 9);   xfer("mul0");
        issue("mul3", OP_MUL, 8'h07, 8'h06);    expect_res("mul3", 8'h2A, 0, 0, 0, 9);   xfer("mul3");
        issue("add", OP_ADD, 8'hF0, 8'h20);     expect_res("add", 8'h10, 0, 1, 0, 1);    xfer("add");

        // Backpressure: result holds and a new request is ignored while DONE.
        issue("bp", OP_AND, 8'h33, 8'hF0);
        expect_res("bp", 8'h30, 0, 0, 0, 1);
        in_valid = 1'b1;
        op = OP_OR;
        a = 8'h0F;
        b = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp", "out_valid_hold", out_valid, 1);
            chk("bp", "result_hold", result, 8'h30);
            chk("bp", "in_ready_hold", in_ready, 0);
        end
        in_valid = 1'b0;
        xfer("bp");

        issue("ill", 4'd12, 8'h33, 8'hF0);    expect_res("ill", 8'h00, 1, 0, 1, 1);   xfer("ill");
        issue("clr", OP_ADD, 8'hF0, 8'h20);   expect_res("clr", 8'h10, 0, 1, 0, 1);   xfer("clr");

        // Reset in the fourth BUSY cycle of a multiply aborts it.
        op = OP_MUL;
        a = 8'h0F;
        b = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rstmul", "out_valid_busy", out_valid, 0);
        rst = 1'b1;
        #1;
        chk("rstmul", "in_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rstmul", "out_valid", out_valid, 0);
        chk("rstmul", "result", result, 0);
        chk("rstmul", "in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rstmul", "out_valid_later", out_valid, 0);
        chk("rstmul", "in_ready_later", in_ready, 1);

        issue("and2", OP_AND, 8'h33, 8'hF0);  expect_res("and2", 8'h30, 0, 0, 0, 1);  xfer("and2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
